// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART Tx between RX echo and manual bytes; valid pulse to tx_send is 3 cycles.
// No backpressure: one pending byte per source, extra bytes are dropped into sticky ovf; busy handshake times out.
module uart_tx_arbiter #(
    parameter logic [19:0] ACK_TIMEOUT = 20'd1000000
) (
    input  logic       src_clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       sw_valid,
    input  logic [7:0] sw_data,
    input  logic       tx_bussy,
    output logic       tx_send,
    output logic [7:0] tx_data,
    output logic       grant_src,
    output logic       active,
    output logic [1:0] ovf,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, LOAD, ASSERT, WAIT_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  pend_q, pend_d;
    logic [7:0]  rx_buf_q, rx_buf_d;
    logic [7:0]  sw_buf_q, sw_buf_d;
    logic        send_q, send_d;
    logic [7:0]  data_q, data_d;
    logic        src_q, src_d;
    logic        last_q, last_d;
    logic [1:0]  ovf_q, ovf_d;
    logic        terr_q, terr_d;
    logic [19:0] cnt_q, cnt_d;
    logic        bsy_s1_q, bsy_s2_q;
    logic        grant;
    logic        sel;
    logic        cnt_exp;

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pend_q   <= 2'b00;
            rx_buf_q <= 8'h00;
            sw_buf_q <= 8'h00;
            send_q   <= 1'b0;
            data_q   <= 8'h00;
            src_q    <= 1'b0;
            last_q   <= 1'b1;
            ovf_q    <= 2'b00;
            terr_q   <= 1'b0;
            cnt_q    <= 20'd0;
            bsy_s1_q <= 1'b0;
            bsy_s2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            rx_buf_q <= rx_buf_d;
            sw_buf_q <= sw_buf_d;
            send_q   <= send_d;
            data_q   <= data_d;
            src_q    <= src_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
            bsy_s1_q <= tx_bussy;
            bsy_s2_q <= bsy_s1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        send_d   = send_q;
        data_d   = data_q;
        src_d    = src_q;
        last_d   = last_q;
        terr_d   = terr_q;
        cnt_d    = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;
        cnt_exp  = (cnt_q == ACK_TIMEOUT - 20'd1);
        grant    = 1'b0;
        sel      = 1'b0;
        pend_d   = pend_q;
        rx_buf_d = rx_buf_q;
        sw_buf_d = sw_buf_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (ena && (pend_q != 2'b00)) begin
                    grant   = 1'b1;
                    // On a tie the source that did not finish last wins.
                    sel     = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                    data_d  = sel ? sw_buf_q : rx_buf_q;
                    src_d   = sel;
                    cnt_d   = 20'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = cnt_q;
                send_d  = 1'b1;
                state_d = ASSERT;
            end
            ASSERT: begin
                if (bsy_s2_q) begin
                    send_d  = 1'b0;
                    cnt_d   = 20'd0;
                    state_d = WAIT_DONE;
                end else if (cnt_exp) begin
                    send_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bsy_s2_q) begin
                    last_d  = src_q;
                    state_d = IDLE;
                end else if (cnt_exp) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!ena) begin
            pend_d = 2'b00;
        end else begin
            if (grant) pend_d[sel] = 1'b0;
            // A byte arriving in its own grant cycle refills the slot instead of overflowing.
            if (rx_valid) begin
                if (!pend_q[0] || (grant && !sel)) begin
                    rx_buf_d  = rx_data;
                    pend_d[0] = 1'b1;
                end else begin
                    ovf_d[0] = 1'b1;
                end
            end
            if (sw_valid) begin
                if (!pend_q[1] || (grant && sel)) begin
                    sw_buf_d  = sw_data;
                    pend_d[1] = 1'b1;
                end else begin
                    ovf_d[1] = 1'b1;
                end
            end
        end
    end

    assign tx_send     = send_q;
    assign tx_data     = data_q;
    assign grant_src   = src_q;
    assign active      = (state_q != IDLE);
    assign ovf         = ovf_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: default-timeout instance with a Tx busy model, plus a 50-cycle-timeout instance with busy stuck low.
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       sw_valid = 1'b0;
    logic [7:0] sw_data = 8'h00;
    logic       tx_bussy = 1'b0;
    logic       to_bussy = 1'b0;
    logic       bsy_auto = 1'b1;

    logic       tx_send, grant_src, active, timeout_err;
    logic [7:0] tx_data;
    logic [1:0] ovf;
    logic       to_send, to_src, to_active, to_terr;
    logic [7:0] to_data;
    logic [1:0] to_ovf;

    typedef struct {
        logic       src;
        logic [7:0] dat;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .src_clk(clk), .rst_n(rst_n), .ena(ena),
        .rx_valid(rx_valid), .rx_data(rx_data), .sw_valid(sw_valid), .sw_data(sw_data),
        .tx_bussy(tx_bussy), .tx_send(tx_send), .tx_data(tx_data), .grant_src(grant_src),
        .active(active), .ovf(ovf), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.ACK_TIMEOUT(20'd50)) dut_to (
        .src_clk(clk), .rst_n(rst_n), .ena(ena),
        .rx_valid(rx_valid), .rx_data(rx_data), .sw_valid(sw_valid), .sw_data(sw_data),
        .tx_bussy(to_bussy), .tx_send(to_send), .tx_data(to_data), .grant_src(to_src),
        .active(to_active), .ovf(to_ovf), .timeout_err(to_terr)
    );

    // Tx model: busy rises 10 cycles after send is seen and stays high for 100 cycles.
    initial forever begin
        @(negedge clk);
        if (bsy_auto && tx_send) begin
            repeat (10) @(negedge clk);
            tx_bussy = 1'b1;
            repeat (100) @(negedge clk);
            tx_bussy = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b0; sw_valid = 1'b0; ena = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        @(negedge clk); rx_valid = 1'b1; rx_data = d;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic pulse_sw(input logic [7:0] d);
        @(negedge clk); sw_valid = 1'b1; sw_data = d;
        @(negedge clk); sw_valid = 1'b0;
    endtask

    task automatic wait_rise(input bit use_to, input int budget, output bit ok);
        logic prev;
        ok = 1'b0;
        prev = use_to ? to_send : tx_send;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((use_to ? to_send : tx_send) && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = use_to ? to_send : tx_send;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!active) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        n_tests++;
        if (tx_send !== 1'b0 || tx_data !== 8'h00 || grant_src !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: send=%b data=%h src=%b active=%b, required 0/00/0/0",
                     tx_send, tx_data, grant_src, active);
        end
        n_tests++;
        if (ovf !== 2'b00 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ovf=%b terr=%b, required 00/0", ovf, timeout_err);
        end
    endtask

    task automatic test_rx_only();
        exp_t e;
        int   cnt;
        bit   ok;
        reset_dut();
        exp_q.push_back('{src: 1'b0, dat: 8'h41});
        pulse_rx(8'h41);
        n_tests++;
        if (active !== 1'b0) begin
            n_fail++; $display("FAIL rx_only_pending_idle: active=%b, required 0", active);
        end
        @(negedge clk);
        n_tests++;
        if (active !== 1'b1 || tx_send !== 1'b0 || tx_data !== 8'h41) begin
            n_fail++;
            $display("FAIL rx_only_load: active=%b send=%b data=%h, required 1/0/41", active, tx_send, tx_data);
        end
        @(negedge clk);
        n_tests++;
        if (tx_send !== 1'b1) begin
            n_fail++; $display("FAIL rx_only_send_n3: send=%b, required 1", tx_send);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (tx_data !== e.dat || grant_src !== e.src) begin
            n_fail++;
            $display("FAIL rx_only_byte: data=%h src=%b, required %h/%b", tx_data, grant_src, e.dat, e.src);
        end
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_send) cnt++;
            else break;
        end
        n_tests++;
        if (cnt != 13) begin
            n_fail++; $display("FAIL rx_only_send_len: %0d cycles, required 13", cnt);
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!tx_bussy) begin ok = 1'b1; break; end
        end
        // Busy fall passes two sync flops, then WAIT_DONE takes one edge to return to IDLE.
        repeat (2) @(negedge clk);
        n_tests++;
        if (!ok || active !== 1'b1) begin
            n_fail++; $display("FAIL rx_only_active_hold: active=%b busy_fell=%b, required 1/1", active, ok);
        end
        @(negedge clk);
        n_tests++;
        if (active !== 1'b0) begin
            n_fail++; $display("FAIL rx_only_active_low: active=%b, required 0", active);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        bit   ok;
        reset_dut();
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h31; sw_valid = 1'b1; sw_data = 8'h32;
        exp_q.push_back('{src: 1'b0, dat: 8'h31});
        exp_q.push_back('{src: 1'b1, dat: 8'h32});
        @(negedge clk);
        rx_valid = 1'b0; sw_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_rise(1'b0, 400, ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!ok || tx_data !== e.dat || grant_src !== e.src || ovf !== 2'b00) begin
                n_fail++;
                $display("FAIL simultaneous_%0d: seen=%b data=%h src=%b ovf=%b, required 1/%h/%b/00",
                         k, ok, tx_data, grant_src, ovf, e.dat, e.src);
            end
        end
        wait_idle(400, ok);
    endtask

    task automatic test_fairness();
        exp_t e;
        bit   ok;
        reset_dut();
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'hA0; sw_valid = 1'b1; sw_data = 8'hB0;
        for (int k = 0; k < 6; k++)
            exp_q.push_back('{src: k[0], dat: (k[0] ? 8'hB0 : 8'hA0)});
        for (int k = 0; k < 6; k++) begin
            wait_rise(1'b0, 400, ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL fairness_timeout_%0d: no send, required send", k);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e.dat || grant_src !== e.src) begin
                    n_fail++;
                    $display("FAIL fairness_%0d: data=%h src=%b, required %h/%b", k, tx_data, grant_src, e.dat, e.src);
                end
            end
        end
        rx_valid = 1'b0; sw_valid = 1'b0; ena = 1'b0;
        wait_idle(400, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL fairness_drain: active=%b, required 0", active);
        end
        ena = 1'b1;
    endtask

    task automatic test_overflow();
        exp_t e;
        bit   ok;
        bit   extra;
        reset_dut();
        exp_q.push_back('{src: 1'b0, dat: 8'h55});
        exp_q.push_back('{src: 1'b1, dat: 8'h10});
        pulse_rx(8'h55);
        wait_rise(1'b0, 400, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || tx_data !== e.dat || grant_src !== e.src) begin
            n_fail++; $display("FAIL overflow_rx: seen=%b data=%h src=%b, required 1/%h/%b", ok, tx_data, grant_src, e.dat, e.src);
        end
        pulse_sw(8'h10);
        pulse_sw(8'h20);
        n_tests++;
        if (ovf !== 2'b10) begin
            n_fail++; $display("FAIL overflow_flag: ovf=%b, required 10", ovf);
        end
        wait_rise(1'b0, 400, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || tx_data !== e.dat || grant_src !== e.src) begin
            n_fail++; $display("FAIL overflow_sw: seen=%b data=%h src=%b, required 1/%h/%b", ok, tx_data, grant_src, e.dat, e.src);
        end
        wait_idle(400, ok);
        extra = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_send || active) extra = 1'b1;
        end
        n_tests++;
        if (!ok || extra || ovf !== 2'b10) begin
            n_fail++; $display("FAIL overflow_drop: idle=%b extra=%b ovf=%b, required 1/0/10", ok, extra, ovf);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok;
        int   cnt;
        bsy_auto = 1'b0;
        reset_dut();
        exp_q.push_back('{src: 1'b0, dat: 8'h77});
        exp_q.push_back('{src: 1'b0, dat: 8'h78});
        pulse_rx(8'h77);
        wait_rise(1'b1, 50, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || to_data !== e.dat || to_src !== e.src || to_terr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_first: seen=%b data=%h src=%b terr=%b, required 1/%h/%b/0", ok, to_data, to_src, to_terr, e.dat, e.src);
        end
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (to_send) cnt++;
            else break;
        end
        n_tests++;
        if (cnt != 50) begin
            n_fail++; $display("FAIL timeout_len: %0d cycles, required 50", cnt);
        end
        n_tests++;
        if (to_terr !== 1'b1 || to_active !== 1'b0) begin
            n_fail++; $display("FAIL timeout_flag: terr=%b active=%b, required 1/0", to_terr, to_active);
        end
        pulse_rx(8'h78);
        wait_rise(1'b1, 50, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || to_data !== e.dat || to_src !== e.src) begin
            n_fail++; $display("FAIL timeout_next: seen=%b data=%h src=%b, required 1/%h/%b", ok, to_data, to_src, e.dat, e.src);
        end
    endtask

    task automatic test_reset_mid_assert();
        bit ok;
        bsy_auto = 1'b0;
        reset_dut();
        pulse_sw(8'h5A);
        wait_rise(1'b0, 50, ok);
        repeat (3) @(negedge clk);
        n_tests++;
        if (!ok || tx_send !== 1'b1 || grant_src !== 1'b1 || tx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL mid_assert_pre: seen=%b send=%b src=%b data=%h, required 1/1/1/5a", ok, tx_send, grant_src, tx_data);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_send !== 1'b0 || tx_data !== 8'h00 || grant_src !== 1'b0 || active !== 1'b0 ||
            ovf !== 2'b00 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_assert_reset: send=%b data=%h src=%b active=%b ovf=%b terr=%b, required all 0",
                     tx_send, tx_data, grant_src, active, ovf, timeout_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ena_off();
        bit bad;
        reset_dut();
        ena = 1'b0;
        pulse_rx(8'h12);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_send || active) bad = 1'b1;
        end
        ena = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx_send || active) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL ena_off_ignore: transfer started, required none");
        end
        // Request captured with ena high, then ena drops before IDLE can grant it.
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h13;
        @(negedge clk); rx_valid = 1'b0; ena = 1'b0;
        @(negedge clk); ena = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_send || active) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL ena_off_clear: pending byte sent, required dropped");
        end
    endtask

    initial begin
        test_reset();
        test_rx_only();
        test_simultaneous();
        test_fairness();
        test_overflow();
        test_timeout();
        test_reset_mid_assert();
        test_ena_off();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
